// File: rtl/uart_tx_fifo_if.sv
// Valid/ready word handshake between a producer and the uart_tx_fifo input FIFO.
// A word moves on a rising clk edge where tx_valid and tx_ready are both high.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: LSB-first frames of START, DATA_BITS data, optional parity
// and STOP_BITS stop bits. Define UART_TX_PARITY_EN to insert the parity bit after the data.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_fifo_if.slave               bus,
  output logic                        tx_pin,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic [LW-1:0] DEPTH_LVL = LW'(FIFO_DEPTH);

  // Reject configurations the datapath widths cannot represent.
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shifter, shift_n;
  logic                 pin_n;
  logic                 bit_end;
  logic                 start_frame;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit, parity_n;
`endif

  assign bus.tx_ready = (level != DEPTH_LVL);
  assign push         = bus.tx_valid & bus.tx_ready;
  assign head         = mem[rd_ptr];
  assign fifo_level   = level;
  assign tx_busy      = (state != IDLE) | (level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shifter    <= '0;
      tx_pin     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shifter    <= shift_n;
      tx_pin     <= pin_n;
`ifdef UART_TX_PARITY_EN
      parity_bit <= parity_n;
`endif
    end
  end

  // tx_pin is registered from the next-state value, so the line level always matches the state.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shift_n     = shifter;
    pin_n       = tx_pin;
    pop         = 1'b0;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_n    = parity_bit;
`endif
    bit_end     = (cnt == CNT_LAST);

    case (state)
      IDLE: begin
        pin_n = 1'b1;
        if (level != '0) start_frame = 1'b1;
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
          pin_n   = shifter[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = shifter >> 1;
          if (idx == DATA_LAST) begin
            idx_n   = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            pin_n   = parity_bit;
`else
            state_n = STOP;
            pin_n   = 1'b1;
`endif
          end else begin
            idx_n = idx + 1'b1;
            pin_n = shifter[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = STOP;
          pin_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == STOP_LAST) begin
            // Back-to-back frames: a queued word starts right after the last stop clock.
            if (level != '0) begin
              start_frame = 1'b1;
            end else begin
              state_n = IDLE;
              pin_n   = 1'b1;
            end
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        pin_n   = 1'b1;
      end
    endcase

    if (start_frame) begin
      pop      = 1'b1;
      shift_n  = head;
      cnt_n    = '0;
      idx_n    = '0;
      state_n  = START;
      pin_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_n = (PARITY_ODD != 0) ? ~^head : ^head;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-table timing checks, a decoding scoreboard
// monitor, back-to-back, FIFO-full, two-stop-bit/odd-parity and mid-frame reset sequences.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB  = 1 + 8 + P + 1;
  localparam int NB2 = 1 + 7 + P + 2;
  localparam int F   = NB * CPB;
  localparam int F2  = NB2 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8)) bus ();
  uart_tx_fifo_if #(.DATA_BITS(7)) bus2 ();

  logic       tx_pin, tx_busy;
  logic [2:0] fifo_level;
  logic       tx_pin2, tx_busy2;
  logic [2:0] fifo_level2;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1),
                 .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .tx_pin(tx_pin), .tx_busy(tx_busy), .fifo_level(fifo_level)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2),
                 .FIFO_DEPTH(DEPTH), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .tx_pin(tx_pin2), .tx_busy(tx_busy2), .fifo_level(fifo_level2)
  );

  int tests = 0;
  int fails = 0;
  int cur   = 0;
  int rst_count = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;
  vec_t vec[5];
  logic [10:0] exp2[2];

  always @(posedge rst) rst_count++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic toCycle(input int t);
    while (cur < t) begin
      @(negedge clk);
      cur++;
    end
  endtask

  // Called at a negedge; holds tx_valid until the word is accepted, returns one negedge later.
  task automatic applyStimulus(input logic [7:0] d);
    int guard = 0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    while (!bus.tx_ready && guard < 500) begin
      @(negedge clk);
      cur++;
      guard++;
    end
    if (!bus.tx_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL push_timeout: got tx_ready=0, expected 1 within 500 clks");
    end else begin
      sb.push_back(d);
    end
    @(negedge clk);
    cur++;
  endtask

  task automatic waitIdle(input string name, input int bound);
    int n = 0;
    while (tx_busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, tx_busy, 0);
  endtask

  // Independent frame decoder: samples mid-bit and checks words against the scoreboard.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] exp;
    logic s0, s1, pb;
    int rc;
    pb = 1'b0;
    forever begin
      @(negedge tx_pin);
      if (rst) continue;
      rc = rst_count;
      repeat (CPB / 2) @(negedge clk);
      s0 = tx_pin;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        got[i] = tx_pin;
      end
`ifdef UART_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      pb = tx_pin;
`endif
      repeat (CPB) @(negedge clk);
      s1 = tx_pin;
      if (rc == rst_count) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL mon_unexpected_frame: got word 0x%0h, expected no frame", got);
        end else begin
          exp = sb.pop_front();
          checkOutput("mon_data", got, exp);
          checkOutput("mon_start", s0, 0);
          checkOutput("mon_stop", s1, 1);
`ifdef UART_TX_PARITY_EN
          checkOutput("mon_parity", pb, ^exp);
`else
          checkOutput("mon_no_parity", pb, 0);
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 400000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [10:0] got_frame;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus2.tx_valid = 1'b0;
    bus2.tx_data  = '0;

`ifdef UART_TX_PARITY_EN
    vec[0] = '{8'h55, 11'b1_0_01010101_0};
    vec[1] = '{8'h07, 11'b1_1_00000111_0};
    vec[2] = '{8'h80, 11'b1_1_10000000_0};
    vec[3] = '{8'h00, 11'b1_0_00000000_0};
    vec[4] = '{8'hFF, 11'b1_0_11111111_0};
    exp2[0] = 11'b11_1_1000001_0;
    exp2[1] = 11'b11_0_0101010_0;
`else
    vec[0] = '{8'h55, 11'b0_1_01010101_0};
    vec[1] = '{8'h07, 11'b0_1_00000111_0};
    vec[2] = '{8'h80, 11'b0_1_10000000_0};
    vec[3] = '{8'h00, 11'b0_1_00000000_0};
    vec[4] = '{8'hFF, 11'b0_1_11111111_0};
    exp2[0] = 11'b0_11_1000001_0;
    exp2[1] = 11'b0_11_0101010_0;
`endif

    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_pin", tx_pin, 1);
    checkOutput("reset_busy", tx_busy, 0);
    checkOutput("reset_ready", bus.tx_ready, 1);
    checkOutput("reset_level", fifo_level, 0);
    checkOutput("reset_pin2", tx_pin2, 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single frames: exact start edge, bit values at mid-bit, busy drop edge.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vec[v].data);
      bus.tx_valid = 1'b0;
      cur = 0;
      got_frame = '0;
      checkOutput("pre_start_pin", tx_pin, 1);
      checkOutput("level_after_push", fifo_level, 1);
      toCycle(1);
      checkOutput("start_edge_pin", tx_pin, 0);
      checkOutput("level_after_pop", fifo_level, 0);
      for (int i = 0; i < NB; i++) begin
        toCycle(3 + CPB * i);
        got_frame[i] = tx_pin;
      end
      checkOutput("frame_bits", got_frame, vec[v].frame);
      toCycle(F);
      checkOutput("busy_last_stop_clk", tx_busy, 1);
      toCycle(F + 1);
      checkOutput("busy_after_frame", tx_busy, 0);
      checkOutput("idle_pin", tx_pin, 1);
      repeat (2) @(negedge clk);
    end

    // Three words on consecutive clocks: levels and gapless frame boundaries.
    applyStimulus(8'hA5);
    cur = 0;
    checkOutput("b2b_level0", fifo_level, 1);
    applyStimulus(8'h3C);
    checkOutput("b2b_level1", fifo_level, 1);
    applyStimulus(8'hFF);
    bus.tx_valid = 1'b0;
    checkOutput("b2b_level2", fifo_level, 2);
    toCycle(F);
    checkOutput("b2b_stop1", tx_pin, 1);
    toCycle(F + 1);
    checkOutput("b2b_start2", tx_pin, 0);
    checkOutput("b2b_level_f2", fifo_level, 1);
    toCycle(2 * F);
    checkOutput("b2b_stop2", tx_pin, 1);
    toCycle(2 * F + 1);
    checkOutput("b2b_start3", tx_pin, 0);
    checkOutput("b2b_level_f3", fifo_level, 0);
    waitIdle("b2b_idle", 4 * F);

    // FIFO full: six words with valid held high; the sixth waits for the first pop after full.
    applyStimulus(8'h11);
    cur = 0;
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    applyStimulus(8'h55);
    checkOutput("full_level", fifo_level, 4);
    checkOutput("full_ready", bus.tx_ready, 0);
    applyStimulus(8'h66);
    bus.tx_valid = 1'b0;
    checkOutput("full_accept_cycle", cur, F + 2);
    checkOutput("full_level_refill", fifo_level, 4);
    waitIdle("full_idle", 8 * F);

    // Two stop bits, 7 data bits, odd parity when enabled; second word fixes the stop length.
    @(negedge clk);
    bus2.tx_valid = 1'b1;
    bus2.tx_data  = 7'h41;
    @(negedge clk);
    cur = 0;
    bus2.tx_data  = 7'h2A;
    @(negedge clk);
    cur = 1;
    bus2.tx_valid = 1'b0;
    for (int f = 0; f < 2; f++) begin
      got_frame = '0;
      for (int i = 0; i < NB2; i++) begin
        toCycle(f * F2 + 3 + CPB * i);
        got_frame[i] = tx_pin2;
      end
      checkOutput("stop2_frame_bits", got_frame, exp2[f]);
      if (f == 0) begin
        toCycle(F2);
        checkOutput("stop2_last_stop_clk", tx_pin2, 1);
        toCycle(F2 + 1);
        checkOutput("stop2_next_start", tx_pin2, 0);
      end
    end
    toCycle(2 * F2 + 1);
    checkOutput("stop2_busy_done", tx_busy2, 0);

    repeat (2) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);

    // Mid-frame reset with a word still queued: outputs clear at once, nothing resumes.
    applyStimulus(8'h3C);
    cur = 0;
    applyStimulus(8'hC3);
    bus.tx_valid = 1'b0;
    toCycle(15);
    rst = 1'b1;
    #1;
    checkOutput("midrst_pin", tx_pin, 1);
    checkOutput("midrst_busy", tx_busy, 0);
    checkOutput("midrst_ready", bus.tx_ready, 1);
    checkOutput("midrst_level", fifo_level, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    begin
      int lows = 0;
      int busys = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (!tx_pin) lows++;
        if (tx_busy) busys++;
      end
      checkOutput("post_reset_pin_low_clks", lows, 0);
      checkOutput("post_reset_busy_clks", busys, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
